// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar echo timer: FSM state encoding and the
// default timing constants used by the top-level parameters.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_t;

  localparam int DEF_CLKS_PER_US = 100;
  localparam int DEF_TRIG_US     = 10;
  localparam int DEF_TIMEOUT_US  = 30000;

  // Larger of two integers, used to size shared counters at elaboration.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/us_prescaler.sv
// Modulo-DIV cycle counter producing a one-cycle tick every DIV clocks.
// A synchronous clear restarts the count at zero and suppresses the tick.
module us_prescaler #(
  parameter int DIV = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..DIV-1 and wrap; clear forces the phase back to zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/sonar_echo_timer.sv
// Ultrasonic ranging front-end: fires a trigger pulse, times the echo in
// whole microseconds, and holds the result under a valid/ack handshake.
// Also provides the free-running microsecond counter exported to reg3.
module sonar_echo_timer
  import sonar_pkg::*;
#(
  parameter int CLKS_PER_US = DEF_CLKS_PER_US,
  parameter int TRIG_US     = DEF_TRIG_US,
  parameter int TIMEOUT_US  = DEF_TIMEOUT_US,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             echo_in,
  input  logic             ack,
  output logic             trig_out,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] echo_us,
  output logic [CNT_W-1:0] us_count
);

  // Trigger width and timeout window are tracked in raw clock cycles so the
  // timeout lands exactly TIMEOUT_US microseconds after the trigger ends,
  // independent of where the measurement prescaler is restarted.
  localparam int TRIG_CYC = TRIG_US * CLKS_PER_US;
  localparam int TMO_CYC  = TIMEOUT_US * CLKS_PER_US;
  localparam int CYC_W    = $clog2(max2(TRIG_CYC, TMO_CYC) + 1);

  localparam logic [CYC_W-1:0] TRIG_LAST   = CYC_W'(TRIG_CYC - 1);
  localparam logic [CYC_W-1:0] TMO_LAST    = CYC_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_US);

  state_t           state;
  logic [CYC_W-1:0] cyc;
  logic [2:0]       echo_sr;
  logic             echo_rise;
  logic             echo_fall;
  logic             free_tick;
  logic             meas_tick;
  logic             meas_clear;
  logic             echo_inc;

  // Two synchronizer flops plus one history flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_sr <= '0;
    end else begin
      echo_sr <= {echo_sr[1:0], echo_in};
    end
  end

  assign echo_rise = echo_sr[1] & ~echo_sr[2];
  assign echo_fall = ~echo_sr[1] & echo_sr[2];

  // Free-running microsecond base; never stalled by the measurement.
  us_prescaler #(.DIV(CLKS_PER_US)) u_free_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .tick  (free_tick)
  );

  // Measurement base is re-phased at trigger end and again at echo rise so
  // that echo_us is the floor of the high time in microseconds.
  assign meas_clear = ((state == TRIG) && (cyc == TRIG_LAST)) ||
                      ((state == WAIT_RISE) && echo_rise);

  us_prescaler #(.DIV(CLKS_PER_US)) u_meas_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (meas_clear),
    .tick  (meas_tick)
  );

  assign echo_inc = meas_tick && (echo_us < TIMEOUT_VAL);

  // Free-running microsecond counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      us_count <= '0;
    end else if (free_tick) begin
      us_count <= us_count + CNT_W'(1);
    end
  end

  // Measurement FSM with registered outputs and result handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cyc      <= '0;
      trig_out <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      echo_us  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // start beats ack when both arrive together
          if (start) begin
            state    <= TRIG;
            cyc      <= '0;
            trig_out <= 1'b1;
            busy     <= 1'b1;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            echo_us  <= '0;
          end else if (ack) begin
            valid <= 1'b0;
          end
        end

        TRIG: begin
          if (cyc == TRIG_LAST) begin
            state    <= WAIT_RISE;
            cyc      <= '0;
            trig_out <= 1'b0;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        WAIT_RISE: begin
          // A level already high here produces no rise pulse, so it is ignored.
          if (cyc == TMO_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            valid   <= 1'b1;
            timeout <= 1'b1;
            echo_us <= TIMEOUT_VAL;
          end else begin
            cyc <= cyc + CYC_W'(1);
            if (echo_rise) begin
              state <= MEASURE;
            end
          end
        end

        MEASURE: begin
          if (echo_fall) begin
            state   <= DONE;
            busy    <= 1'b0;
            valid   <= 1'b1;
            timeout <= 1'b0;
            if (echo_inc) begin
              echo_us <= echo_us + CNT_W'(1);
            end
          end else if (cyc == TMO_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            valid   <= 1'b1;
            timeout <= 1'b1;
            echo_us <= TIMEOUT_VAL;
          end else begin
            cyc <= cyc + CYC_W'(1);
            if (echo_inc) begin
              echo_us <= echo_us + CNT_W'(1);
            end
          end
        end

        default: begin
          state    <= IDLE;
          trig_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_echo_timer.sv
// Directed bench for sonar_echo_timer with CLKS_PER_US=4, TRIG_US=2,
// TIMEOUT_US=50: a table of echo widths plus hand-written corner sequences.
module tb_sonar_echo_timer;

  localparam int CLKS_PER_US = 4;
  localparam int TRIG_US     = 2;
  localparam int TIMEOUT_US  = 50;
  localparam int CNT_W       = 32;

  logic             clock;
  logic             reset;
  logic             start;
  logic             echo_in;
  logic             ack;
  logic             trig_out;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] echo_us;
  logic [CNT_W-1:0] us_count;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string name;
    int    delay;   // cycles of low echo after the trigger ends
    int    width;   // cycles of high echo
    int    exp_us;
    int    exp_tmo;
  } vec_t;

  vec_t vecs[7];

  sonar_echo_timer #(
    .CLKS_PER_US (CLKS_PER_US),
    .TRIG_US     (TRIG_US),
    .TIMEOUT_US  (TIMEOUT_US),
    .CNT_W       (CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .echo_in  (echo_in),
    .ack      (ack),
    .trig_out (trig_out),
    .busy     (busy),
    .valid    (valid),
    .timeout  (timeout),
    .echo_us  (echo_us),
    .us_count (us_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clocks; inputs and samples sit 1 time unit after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Counts samples with trig_out high, ending on the first sample it is low.
  task automatic wait_trig_end(output int high_cycles);
    high_cycles = 0;
    for (int i = 0; i < 100 && trig_out; i++) begin
      high_cycles++;
      tick(1);
    end
    check("trig_end_seen", 32'(trig_out), 0);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    for (int i = 0; i < 400 && !valid; i++) begin
      tick(1);
      cycles++;
    end
    check("valid_seen", 32'(valid), 1);
  endtask

  initial begin
    int hc;
    int wc;

    vecs[0] = '{"echo80",    5,  80, 20, 0};
    vecs[1] = '{"echo3",     0,   3,  0, 0};
    vecs[2] = '{"echo4",     0,   4,  1, 0};
    vecs[3] = '{"echo7",     2,   7,  1, 0};
    vecs[4] = '{"echo150",  10, 150, 37, 0};
    vecs[5] = '{"echo190",   0, 190, 47, 0};
    vecs[6] = '{"echo_long", 0, 250, 50, 1};

    reset   = 1'b1;
    start   = 1'b0;
    echo_in = 1'b0;
    ack     = 1'b0;

    // Outputs while reset is held
    tick(2);
    check("rst_trig",    32'(trig_out), 0);
    check("rst_busy",    32'(busy),     0);
    check("rst_valid",   32'(valid),    0);
    check("rst_timeout", 32'(timeout),  0);
    check("rst_echo_us", echo_us,       0);
    check("rst_us_count", us_count,     0);

    // us_count first ticks CLKS_PER_US cycles after release, then every 4
    reset = 1'b0;
    tick(3);
    check("us_count_3", us_count, 0);
    tick(1);
    check("us_count_4", us_count, 1);
    tick(396);
    check("us_count_400", us_count, 100);
    check("idle_busy", 32'(busy), 0);

    // Trigger width, busy, and timeout with no echo at all
    pulse_start();
    check("trig_rise", 32'(trig_out), 1);
    check("busy_trig", 32'(busy), 1);
    wait_trig_end(hc);
    check("trig_width", hc, 8);
    check("busy_wait", 32'(busy), 1);
    wait_valid(wc);
    check("tmo_latency", wc, 200);
    check("tmo_flag", 32'(timeout), 1);
    check("tmo_echo_us", echo_us, 50);
    check("tmo_busy", 32'(busy), 0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("tmo_ack_valid", 32'(valid), 0);

    // Table of echo widths
    for (int v = 0; v < 7; v++) begin
      pulse_start();
      check({vecs[v].name, "_clr_valid"}, 32'(valid), 0);
      wait_trig_end(hc);
      tick(vecs[v].delay);
      echo_in = 1'b1;
      tick(vecs[v].width);
      echo_in = 1'b0;
      wait_valid(wc);
      check({vecs[v].name, "_us"},  echo_us, vecs[v].exp_us);
      check({vecs[v].name, "_tmo"}, 32'(timeout), vecs[v].exp_tmo);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check({vecs[v].name, "_ack_valid"}, 32'(valid), 0);
      check({vecs[v].name, "_ack_keep"},  echo_us, vecs[v].exp_us);
      tick(5);
    end

    // Echo already high at trigger end must be ignored until it re-rises
    pulse_start();
    tick(2);
    echo_in = 1'b1;
    wait_trig_end(hc);
    tick(5);
    echo_in = 1'b0;
    tick(10);
    echo_in = 1'b1;
    tick(40);
    echo_in = 1'b0;
    wait_valid(wc);
    check("stale_us",  echo_us, 10);
    check("stale_tmo", 32'(timeout), 0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;

    // start while measuring is ignored; no re-trigger
    pulse_start();
    wait_trig_end(hc);
    echo_in = 1'b1;
    tick(20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("mid_start_trig", 32'(trig_out), 0);
    check("mid_start_busy", 32'(busy), 1);
    tick(19);
    echo_in = 1'b0;
    wait_valid(wc);
    check("mid_start_us", echo_us, 10);

    // start and ack together in DONE: start wins, new trigger fires
    start = 1'b1;
    ack   = 1'b1;
    tick(1);
    start = 1'b0;
    ack   = 1'b0;
    check("start_ack_trig",  32'(trig_out), 1);
    check("start_ack_valid", 32'(valid), 0);
    check("start_ack_busy",  32'(busy), 1);
    check("start_ack_echo",  echo_us, 0);

    // Reset during the trigger pulse drops trig_out without a clock edge
    tick(2);
    reset = 1'b1;
    #1;
    check("rst_trig_async", 32'(trig_out), 0);
    check("rst_trig_busy",  32'(busy), 0);
    tick(1);
    reset = 1'b0;

    // Reset during MEASURE: everything cleared, no partial result later
    tick(20);
    pulse_start();
    wait_trig_end(hc);
    echo_in = 1'b1;
    tick(12);
    check("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("rst_meas_trig",  32'(trig_out), 0);
    check("rst_meas_valid", 32'(valid), 0);
    check("rst_meas_busy",  32'(busy), 0);
    check("rst_meas_count", us_count, 0);
    tick(1);
    reset = 1'b0;
    echo_in = 1'b0;
    tick(20);
    check("post_rst_valid", 32'(valid), 0);
    check("post_rst_busy",  32'(busy), 0);
    check("post_rst_echo",  echo_us, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
